// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters; grant +1, tx_wr +3 cycles after request.
// Backpressure: frames are serialised on UART busy; optional watchdog abort under `UART_SCHED_TIMEOUT_EN.
// Baud select is only sampled while idle, so it never changes mid-frame.
module uart_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [2:0]         cfg_baud,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         tx_data,
    output logic               tx_wr,
    output logic               tx_en,
    output logic [2:0]         baud_select,
    output logic               idle,
    output logic               timeout_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WRITE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("uart_tx_scheduler: parameter out of range");
    end

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [PW:0]     idx;
    logic            wd_expire;
    logic            wd_abort;
    logic            frame_end;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
            if (!pick_vld && req[idx[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[PW-1:0];
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_expire = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == S_WRITE || (state == S_WAIT_BUSY && tx_busy)) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && !wd_expire) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    assign wd_abort  = wd_expire && ((state == S_WAIT_BUSY && !tx_busy) ||
                                     (state == S_WAIT_DONE &&  tx_busy));
    assign frame_end = (state == S_WAIT_DONE && !tx_busy) || wd_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            gnt         <= '0;
            done        <= '0;
            tx_data     <= '0;
            tx_wr       <= 1'b0;
            tx_en       <= 1'b0;
            baud_select <= 3'b000;
            idle        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            tx_en       <= 1'b1;
            done        <= '0;
            tx_wr       <= 1'b0;
            timeout_err <= 1'b0;
            if (frame_end) begin
                done        <= gnt;
                gnt         <= '0;
                rr_ptr      <= (sel == PW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                idle        <= 1'b1;
                timeout_err <= wd_abort;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        baud_select <= cfg_baud;
                        if (pick_vld) begin
                            sel     <= pick;
                            gnt     <= N_REQ'(1) << pick;
                            tx_data <= req_data[{pick, 3'b000} +: 8];
                            idle    <= 1'b0;
                            state   <= S_GRANT;
                        end
                    end
                    S_GRANT:     state <= S_WRITE;
                    S_WRITE: begin
                        tx_wr <= 1'b1;
                        state <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: if (tx_busy) state <= S_WAIT_DONE;
                    default:     state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART busy model.
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [2:0]  cfg_baud;
    logic        tx_busy;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_en;
    logic [2:0]  baud_select;
    logic        idle;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    bit model_en = 1'b1;
    int wr_cnt   = 0;
    int done_cnt = 0;

    uart_tx_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .cfg_baud(cfg_baud),
        .tx_busy(tx_busy), .gnt(gnt), .done(done), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_en(tx_en), .baud_select(baud_select), .idle(idle), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // UART model: busy for busy_len cycles starting right after each write strobe.
    always begin
        @(posedge clk);
        #1;
        if (!reset) busy_cnt = 0;
        else if (model_en && tx_wr) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        tx_busy = (busy_cnt > 0);
    end

    always @(negedge clk) begin
        if (tx_wr) wr_cnt++;
        if (done != 4'b0000) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done != 4'b0000), 32'd1);
    endtask

    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int         lens    [5] = '{3, 40, 7, 15, 22};
    int         wr_base;
    int         done_base;

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0000_AA00;
        cfg_baud = 3'b000;
        tx_busy  = 1'b0;
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_wr", 32'(tx_wr), 32'h0);
        check("rst_tx_en", 32'(tx_en), 32'h0);
        check("rst_baud", 32'(baud_select), 32'h0);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b1;
        tick();
        check("tx_en_after_rst", 32'(tx_en), 32'h1);

        // T1: single requester
        req = 4'b0010;
        busy_len = 10;
        wr_base = wr_cnt;
        tick();
        check("t1_gnt", 32'(gnt), 32'h2);
        check("t1_tx_data", 32'(tx_data), 32'hAA);
        check("t1_idle_low", 32'(idle), 32'h0);
        tick();
        check("t1_wr_early", 32'(tx_wr), 32'h0);
        tick();
        check("t1_wr", 32'(tx_wr), 32'h1);
        wait_done("t1");
        req = 4'b0000;
        check("t1_done", 32'(done), 32'h2);
        check("t1_gnt_clr", 32'(gnt), 32'h0);
        check("t1_idle", 32'(idle), 32'h1);
        check("t1_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        tick();
        check("t1_done_pulse", 32'(done), 32'h0);

        // T2: round robin with all requesters held
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            busy_len = lens[k];
            tick();
            check($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
            check($sformatf("t2_data%0d", k), 32'(tx_data), 32'(exp_dat[k]));
            wait_done($sformatf("t2_f%0d", k));
            check($sformatf("t2_done%0d", k), 32'(done), 32'(exp_gnt[k]));
            if (k == 4) req = 4'b0000;
        end

        // T3: baud change mid-frame is deferred
        tick();
        busy_len = 12;
        req = 4'b0001;
        tick();
        check("t3_gnt", 32'(gnt), 32'h1);
        tick();
        cfg_baud = 3'b111;
        tick();
        check("t3_baud_hold", 32'(baud_select), 32'h0);
        wait_done("t3");
        check("t3_baud_at_done", 32'(baud_select), 32'h0);
        busy_len = 30;
        tick();
        check("t3_regnt", 32'(gnt), 32'h1);
        check("t3_baud_new", 32'(baud_select), 32'h7);
        tick();
        tick();
        check("t3_wr", 32'(tx_wr), 32'h1);
        check("t3_baud_at_wr", 32'(baud_select), 32'h7);
        repeat (5) tick();

        // T4: reset while waiting for the frame to end
        done_base = done_cnt;
        reset = 1'b0;
        #1;
        check("t4_gnt", 32'(gnt), 32'h0);
        check("t4_tx_en", 32'(tx_en), 32'h0);
        check("t4_tx_data", 32'(tx_data), 32'h0);
        check("t4_baud", 32'(baud_select), 32'h0);
        check("t4_idle", 32'(idle), 32'h1);
        req = 4'b0011;
        tick();
        tick();
        reset = 1'b1;
        busy_len = 8;
        wr_base = wr_cnt;
        tick();
        check("t4_no_done", 32'(done_cnt - done_base), 32'd0);
        check("t4_gnt_rr0", 32'(gnt), 32'h1);
        check("t4_tx_en_on", 32'(tx_en), 32'h1);

        // T5: requester withdraws after grant
        req = 4'b0000;
        check("t5_tx_data", 32'(tx_data), 32'h11);
        wait_done("t5");
        check("t5_done", 32'(done), 32'h1);
        check("t5_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        tick();
        check("t5_gnt_idle", 32'(gnt), 32'h0);
        check("t5_idle", 32'(idle), 32'h1);
        check("t5_no_timeout", 32'(timeout_err), 32'h0);

`ifdef UART_SCHED_TIMEOUT_EN
        // T6: busy never rises, watchdog aborts
        model_en = 1'b0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("t6_wr", 32'(tx_wr), 32'h1);
        repeat (19) tick();
        check("t6_err_early", 32'(timeout_err), 32'h0);
        tick();
        check("t6_err", 32'(timeout_err), 32'h1);
        check("t6_done", 32'(done), 32'h4);
        check("t6_idle", 32'(idle), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
